// File: rtl/apb_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_request_arbiter
// Purpose  : Round-robin arbiter that shares one APB master among NumReq
//            local requesters. Each accepted request is latched, issued to the
//            master as a one-cycle Start command, and tracked through the
//            master's Busy handshake. It ends with a one-cycle per-requester
//            completion pulse and registered read data.
// Ports    : PCLK, reset          - clock, async active-high reset
//            ReqValid/ReqWrite/ReqAddr/ReqSel/ReqData/ReqStrb
//                                 - flattened requester fields (slice k = req k)
//            ReqGrant, ReqDone    - one-hot accept / completion pulses
//            RespData             - read data, valid with ReqDone
//            Start/RD/WR/Addr/Sel/SendData/Strb
//                                 - command interface to the APB master
//            Busy, DataReceived   - transfer status / read data from master
//            ArbBusy, GrantId     - status: not idle / last granted index
// Revision : 1.0 - initial release
// ============================================================================
module apb_request_arbiter #(
  parameter  int NumReq     = 4,
  parameter  int DataWidth  = 32,
  parameter  int AddrWidth  = 32,
  parameter  int Slaves     = 4,
  localparam int DecoSlaves = $clog2(Slaves),
  localparam int StrbWidth  = DataWidth / 8,
  localparam int IdWidth    = $clog2(NumReq)
) (
  input  logic                            PCLK,
  input  logic                            reset,
  input  logic [NumReq-1:0]               ReqValid,
  input  logic [NumReq-1:0]               ReqWrite,
  input  logic [NumReq*AddrWidth-1:0]     ReqAddr,
  input  logic [NumReq*DecoSlaves-1:0]    ReqSel,
  input  logic [NumReq*DataWidth-1:0]     ReqData,
  input  logic [NumReq*StrbWidth-1:0]     ReqStrb,
  output logic [NumReq-1:0]               ReqGrant,
  output logic [NumReq-1:0]               ReqDone,
  output logic [DataWidth-1:0]            RespData,
  output logic                            Start,
  output logic                            RD,
  output logic                            WR,
  output logic [AddrWidth-1:0]            Addr,
  output logic [DecoSlaves-1:0]           Sel,
  output logic [DataWidth-1:0]            SendData,
  output logic [StrbWidth-1:0]            Strb,
  input  logic                            Busy,
  input  logic [DataWidth-1:0]            DataReceived,
  output logic                            ArbBusy,
  output logic [IdWidth-1:0]              GrantId
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IdWidth-1:0]      r_grant_id;
  logic                    r_write;
  logic [AddrWidth-1:0]    r_addr;
  logic [DecoSlaves-1:0]   r_sel;
  logic [DataWidth-1:0]    r_data;
  logic [StrbWidth-1:0]    r_strb;
  logic [DataWidth-1:0]    r_resp;

  logic                    w_found;
  logic [IdWidth-1:0]      w_win;
  logic [IdWidth-1:0]      w_idx;
  logic [NumReq-1:0]       w_onehot;
  logic                    w_active;
  logic                    w_accept;

  // Round-robin search: start one past the last winner and take the first
  // pending requester. The last winner itself is checked last (i = NumReq).
  always_comb begin
    w_found = 1'b0;
    w_win   = r_grant_id;
    w_idx   = r_grant_id;
    for (int i = 1; i <= NumReq; i++) begin
      w_idx = IdWidth'((int'(r_grant_id) + i) % NumReq);
      if (!w_found && ReqValid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_accept = (r_state == ST_IDLE) && w_found;

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_found) w_next = ST_ISSUE;
      ST_ISSUE:     w_next = ST_WAIT_BUSY;
      // A single-cycle Busy pulse still walks through WAIT_DONE and counts
      // as a finished transfer.
      ST_WAIT_BUSY: if (Busy) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!Busy) w_next = ST_DONE;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Command fields are captured once at accept time so the requester is free
  // to change its inputs from the cycle after the grant.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      r_grant_id <= IdWidth'(NumReq - 1);
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_sel      <= '0;
      r_data     <= '0;
      r_strb     <= '0;
    end else if (w_accept) begin
      r_grant_id <= w_win;
      r_write    <= ReqWrite[w_win];
      r_addr     <= ReqAddr[int'(w_win)*AddrWidth +: AddrWidth];
      r_sel      <= ReqSel[int'(w_win)*DecoSlaves +: DecoSlaves];
      r_data     <= ReqData[int'(w_win)*DataWidth +: DataWidth];
      r_strb     <= ReqWrite[w_win] ? ReqStrb[int'(w_win)*StrbWidth +: StrbWidth]
                                    : '0;
    end
  end

  // Read data is captured on the WAIT_DONE -> DONE transition only; writes
  // leave the previous read value in place.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      r_resp <= '0;
    end else if ((r_state == ST_WAIT_DONE) && !Busy && !r_write) begin
      r_resp <= DataReceived;
    end
  end

  assign w_active = (r_state != ST_IDLE);
  assign w_onehot = NumReq'(1) << r_grant_id;

  assign ReqGrant = (r_state == ST_ISSUE) ? w_onehot : '0;
  assign ReqDone  = (r_state == ST_DONE)  ? w_onehot : '0;
  assign Start    = (r_state == ST_ISSUE);
  assign RD       = w_active & ~r_write;
  assign WR       = w_active &  r_write;
  assign Addr     = r_addr;
  assign Sel      = r_sel;
  assign SendData = r_data;
  assign Strb     = r_strb;
  assign RespData = r_resp;
  assign ArbBusy  = w_active;
  assign GrantId  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_apb_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_request_arbiter
// Purpose  : Self-checking bench for apb_request_arbiter. Requesters and the
//            APB master are modelled inside the bench; expected grants come
//            from a round-robin pick over the pending set, expected read data
//            from the values the master model returns.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_request_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DS = 2;
  localparam int SW = 4;

  logic            PCLK = 1'b0;
  logic            reset;
  logic [N-1:0]    ReqValid, ReqWrite;
  logic [N*AW-1:0] ReqAddr;
  logic [N*DS-1:0] ReqSel;
  logic [N*DW-1:0] ReqData;
  logic [N*SW-1:0] ReqStrb;
  logic [N-1:0]    ReqGrant, ReqDone;
  logic [DW-1:0]   RespData;
  logic            Start, RD, WR;
  logic [AW-1:0]   Addr;
  logic [DS-1:0]   Sel;
  logic [DW-1:0]   SendData;
  logic [SW-1:0]   Strb;
  logic            Busy;
  logic [DW-1:0]   DataReceived;
  logic            ArbBusy;
  logic [1:0]      GrantId;

  apb_request_arbiter #(.NumReq(N), .DataWidth(DW), .AddrWidth(AW), .Slaves(4)) dut (
    .PCLK(PCLK), .reset(reset),
    .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqSel(ReqSel),
    .ReqData(ReqData), .ReqStrb(ReqStrb), .ReqGrant(ReqGrant), .ReqDone(ReqDone),
    .RespData(RespData), .Start(Start), .RD(RD), .WR(WR), .Addr(Addr), .Sel(Sel),
    .SendData(SendData), .Strb(Strb), .Busy(Busy), .DataReceived(DataReceived),
    .ArbBusy(ArbBusy), .GrantId(GrantId)
  );

  always #5 PCLK = ~PCLK;

  int vectors     = 0;
  int miscompares = 0;

  // Requester-side model state
  logic          m_wr   [N];
  logic [AW-1:0] m_addr [N];
  logic [DS-1:0] m_sel  [N];
  logic [DW-1:0] m_data [N];
  logic [SW-1:0] m_strb [N];
  logic [N-1:0]  m_valid;
  int            m_last;
  logic [DW-1:0] m_resp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      ReqWrite[k]          = m_wr[k];
      ReqAddr[k*AW +: AW]  = m_addr[k];
      ReqSel[k*DS +: DS]   = m_sel[k];
      ReqData[k*DW +: DW]  = m_data[k];
      ReqStrb[k*SW +: SW]  = m_strb[k];
    end
    ReqValid = m_valid;
  endtask

  task automatic randreq(input int k);
    m_wr[k]   = 1'($urandom_range(0, 1));
    m_addr[k] = $urandom;
    m_sel[k]  = 2'($urandom_range(0, 3));
    m_data[k] = $urandom;
    m_strb[k] = 4'($urandom_range(0, 15));
  endtask

  // Round-robin rule: first pending requester after the last winner, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // One full transfer. Called in IDLE with at least one request pending; the
  // grant is expected on the next edge. Busy rises the cycle after Start and
  // stays high for wcyc edges.
  task automatic txn(input int wcyc, input bit rereq, input bit withdraw,
                     input logic [DW-1:0] rdata);
    int            id;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DS-1:0] e_sel;
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_strb;
    id     = rr_pick(m_last, m_valid);
    e_wr   = m_wr[id];
    e_addr = m_addr[id];
    e_sel  = m_sel[id];
    e_data = m_data[id];
    e_strb = e_wr ? m_strb[id] : 4'h0;
    tick();
    chk("grant", ReqGrant, 64'(1) << id);
    chk("start", Start, 1);
    chk("grant_id", GrantId, id);
    chk("rd", RD, !e_wr);
    chk("wr", WR, e_wr);
    chk("addr", Addr, e_addr);
    chk("sel", Sel, e_sel);
    chk("senddata", SendData, e_data);
    chk("strb", Strb, e_strb);
    m_last = id;
    if (rereq) begin
      randreq(id);
      m_valid[id] = 1'b1;
    end else begin
      m_valid[id] = 1'b0;
    end
    drive();
    tick();
    chk("start_one_cycle", {Start, ReqGrant}, 0);
    Busy = 1'b1;
    for (int i = 0; i < wcyc; i++) begin
      tick();
      if (withdraw && i == 0) begin m_valid[1] = 1'b1; drive(); end
      if (withdraw && i == 1) begin m_valid[1] = 1'b0; drive(); end
      chk("no_early_done", {ReqDone, ReqGrant, Start}, 0);
    end
    Busy = 1'b0;
    DataReceived = rdata;
    tick();
    if (!e_wr) m_resp = rdata;
    chk("done", ReqDone, 64'(1) << id);
    chk("respdata", RespData, m_resp);
    chk("cmd_stable", {RD, WR, Addr, Strb}, {!e_wr, e_wr, e_addr, e_strb});
    tick();
    chk("back_idle", {ArbBusy, RD, WR, ReqDone, Start}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Busy  = 1'b0;
    tick();
    reset  = 1'b0;
    m_last = N - 1;
    m_resp = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < N; i++) randreq(i);
    m_valid = '0;
    drive();
    DataReceived = '0;
    Busy  = 1'b0;
    reset = 1'b1;
    #2;
    do_reset();

    // Reset state
    chk("rst_outputs", {ReqGrant, ReqDone, RespData, Start, RD, WR, Addr, Sel,
                        SendData, Strb, ArbBusy}, 0);
    chk("rst_grantid", GrantId, 3);

    // Single read from requester 0
    m_wr[0] = 1'b0; m_addr[0] = 32'h10; m_sel[0] = 2'd1; m_strb[0] = 4'hF;
    m_valid[0] = 1'b1;
    drive();
    txn(2, 1'b0, 1'b0, 32'h0000_0400);
    chk("read_resp_400", RespData, 32'h400);

    // Single write from requester 2; read data must survive
    m_wr[2] = 1'b1; m_addr[2] = 32'h1A; m_sel[2] = 2'd0; m_data[2] = 32'h55;
    m_strb[2] = 4'hF; m_valid[2] = 1'b1;
    drive();
    txn(3, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("write_keeps_resp", RespData, 32'h400);

    // Round-robin with all four held continuously
    do_reset();
    for (int i = 0; i < N; i++) randreq(i);
    m_valid = '1;
    drive();
    for (int i = 0; i < 5; i++) begin
      txn(int'($urandom_range(1, 4)), 1'b1, 1'b0, $urandom);
      chk("rr_order", GrantId, i % N);
    end

    // Withdrawal of requester 1 while requester 0 is mid-transfer
    m_valid = '0;
    drive();
    tick();
    tick();
    do_reset();
    randreq(0); randreq(3);
    m_valid = 4'b1001;
    drive();
    txn(3, 1'b0, 1'b1, $urandom);
    txn(1, 1'b0, 1'b0, $urandom);
    chk("after_withdraw", GrantId, 3);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, N - 1));
      if (!m_valid[k]) begin randreq(k); m_valid[k] = 1'b1; end
      drive();
      txn(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0, $urandom);
    end

    // Reset while in WAIT_DONE
    m_valid = '0;
    drive();
    tick();
    tick();
    randreq(0);
    m_valid[0] = 1'b1;
    drive();
    tick();
    m_valid[0] = 1'b0;
    drive();
    tick();
    Busy = 1'b1;
    tick();
    tick();
    chk("pre_reset_busy", ArbBusy, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_cmd", {Start, RD, WR, ReqDone, ArbBusy}, 0);
    chk("async_rst_gid", GrantId, 3);
    Busy = 1'b0;
    tick();
    chk("rst_no_done", ReqDone, 0);
    reset  = 1'b0;
    m_last = N - 1;
    m_resp = '0;
    randreq(0);
    m_valid[0] = 1'b1;
    drive();
    txn(2, 1'b0, 1'b0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_request_arbiter.md
# apb_request_arbiter

Round-robin arbiter that shares one `APBRequester` (APB master) among `NumReq` local requesters. Each accepted request is latched, then the arbiter sequences the requester's `Start`/`RD`/`WR` command interface and waits for the transfer to finish via `Busy`. It returns read data and a per-requester completion pulse. It sits between bus clients (DMA, CPU port, config engine) and the single APB master.

## Interface
- `NumReq`, 4: number of requesters, 2..8.
- `DataWidth`, 32: APB data width.
- `AddrWidth`, 32: APB address width.
- `Slaves`, 4: completer count; `DecoSlaves` = clog2(`Slaves`), `StrbWidth` = `DataWidth`/8 (derived, localparam).
- Clock and reset:
  - `PCLK` input 1: single clock, all state on rising edge.
  - `reset` input 1: asynchronous, active-high; clears all state immediately.
- Requester side, flattened, requester k in slice k:
  - `ReqValid` input `NumReq`: request pending.
  - `ReqWrite` input `NumReq`: 1 = write, 0 = read.
  - `ReqAddr` input `NumReq*AddrWidth`: target address.
  - `ReqSel` input `NumReq*DecoSlaves`: completer index.
  - `ReqData` input `NumReq*DataWidth`: write data.
  - `ReqStrb` input `NumReq*StrbWidth`: write strobes.
  - `ReqGrant` output `NumReq`: one-hot, one-cycle accept pulse.
  - `ReqDone` output `NumReq`: one-hot, one-cycle completion pulse.
  - `RespData` output `DataWidth`: read data, valid with `ReqDone`.
- APB master side:
  - `Start` output 1: one-cycle command pulse.
  - `RD` output 1: read command.
  - `WR` output 1: write command.
  - `Addr` output `AddrWidth`: command address.
  - `Sel` output `DecoSlaves`: command completer index.
  - `SendData` output `DataWidth`: command write data.
  - `Strb` output `StrbWidth`: command strobes.
  - `Busy` input 1: APB master transfer in progress.
  - `DataReceived` input `DataWidth`: read data from APB master.
- Status:
  - `ArbBusy` output 1: state ≠ IDLE.
  - `GrantId` output clog2(`NumReq`): index of the current/last granted requester.

## Operation
- FSM states:
  - IDLE: if any `ReqValid`, select winner, latch its fields, go to ISSUE; otherwise stay.
  - ISSUE: `Start`=1 for exactly one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: stay until `Busy`=1 sampled, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: stay until `Busy`=0 sampled, then go to DONE.
  - DONE: pulse `ReqDone[GrantId]`, go to IDLE.
- Round-robin priority:
  - Search starts at `GrantId`+1 modulo `NumReq`.
  - Reset value of `GrantId` is `NumReq`-1, so requester 0 has first priority after reset.
  - `GrantId` updates only on a grant.
- Requester contract:
  - Fields must be held stable while `ReqValid`=1 until `ReqGrant` is seen.
  - Fields may change, and a new request may be raised, from the cycle after `ReqGrant`.
  - Dropping `ReqValid` before grant withdraws the request, with no side effects.
- Command outputs:
  - `Addr`, `Sel`, `SendData`, `Strb`, `RD`, `WR` come from latched registers.
  - They are stable from ISSUE through DONE.
  - `RD` = ~write, `WR` = write; both are 0 in IDLE.
  - `Strb` is forced to 0 for reads.
- `RespData`:
  - Registered; loaded from `DataReceived` on the WAIT_DONE→DONE edge for reads only.
  - Holds its value otherwise, including across writes.
- Only one transfer is outstanding at a time; requests arriving in non-IDLE states wait.

## Timing
- Reset values: all outputs 0 except `GrantId` = `NumReq`-1; state is IDLE.
- Accept: `ReqValid` sampled high in IDLE at edge N → `ReqGrant` and `Start` both high during cycle N+1 (state ISSUE).
- With requester `Busy` rising the cycle after `Start` and PREADY ending after m cycles, `ReqDone` is high one cycle after `Busy` is first sampled low.
- Back-to-back requests: next grant at the edge leaving DONE→IDLE+1. Minimum gap between `ReqDone` and the next `Start` is 2 cycles.
- Simultaneous `ReqValid` from several requesters: exactly one `ReqGrant` bit, chosen by round-robin order.
- Reset mid-transfer (any state):
  - Outputs clear asynchronously, with no `ReqDone` for the aborted transfer.
  - The pending request is lost; the requester must re-raise it.
  - The APB master shares the same `reset`.
- `Busy` glitch high then low while in WAIT_BUSY is treated as a complete transfer.

## Test plan
- Single read: `ReqValid[0]`, `Addr`=0x10, `Sel`=1, completer returns 0x0000_0400 after 2 wait cycles → one `Start` pulse, `RD`=1, then `ReqDone[0]` with `RespData`=0x400.
- Single write: `ReqValid[2]`, `Addr`=0x1A, data 0x55, `Strb`=4'hF → `WR`=1, `SendData`=0x55, `ReqDone[2]`; `RespData` unchanged from the previous read.
- Round-robin: all four `ReqValid` held continuously → grant order 0,1,2,3,0, and each requester completes exactly once per round.
- Withdrawal: raise then drop `ReqValid[1]` while a requester-0 transfer is in WAIT_DONE → no grant to 1; next grant goes to the next valid requester.
- Reset in WAIT_DONE: assert `reset` mid-transfer → `Start`/`RD`/`WR`/`ReqDone` all 0 immediately, `GrantId`=3, and the next `ReqValid[0]` is granted normally.
